// File: rtl/idu_pkg_ysyx_23060136.sv
// rtl/idu_pkg_ysyx_23060136.sv - shared widths, GPR depths and the issue-entry record
package idu_pkg_ysyx_23060136;
  localparam int IDU_XLEN     = 32;
  localparam int NR_GPR_RV32I = 32;
  localparam int NR_GPR_RV32E = 16;
  localparam int RID_MAX_W    = 5;

  // rd is stored at full RV32I width; RV32E builds zero-extend into it
  typedef struct packed {
    logic [IDU_XLEN-1:0]  pc;
    logic [IDU_XLEN-1:0]  inst;
    logic [IDU_XLEN-1:0]  rs1_data;
    logic [IDU_XLEN-1:0]  rs2_data;
    logic [RID_MAX_W-1:0] rd;
    logic                 rd_wen;
  } idu_issue_t;
endpackage

// File: rtl/idu_scoreboard_ysyx_23060136.sv
// rtl/idu_scoreboard_ysyx_23060136.sv - pending-write bits with write-back-aware lookup
module idu_scoreboard_ysyx_23060136
  import idu_pkg_ysyx_23060136::*;
#(
  parameter int NR_GPR = NR_GPR_RV32I,
  parameter int RID_W  = $clog2(NR_GPR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set_en,
  input  logic [RID_W-1:0] i_set_idx,
  input  logic             i_clr_en,
  input  logic [RID_W-1:0] i_clr_idx,
  input  logic [RID_W-1:0] i_q0_idx,
  input  logic [RID_W-1:0] i_q1_idx,
  input  logic [RID_W-1:0] i_q2_idx,
  output logic             o_q0_pend,
  output logic             o_q1_pend,
  output logic             o_q2_pend
);
  logic [NR_GPR-1:0] r_pending;

  // A write-back landing this cycle already releases its register
  function automatic logic f_eff(input logic [RID_W-1:0] idx);
    return r_pending[idx] && !(i_clr_en && i_clr_idx == idx);
  endfunction

  assign o_q0_pend = f_eff(i_q0_idx);
  assign o_q1_pend = f_eff(i_q1_idx);
  assign o_q2_pend = f_eff(i_q2_idx);

  // Bit 0 is never written after reset, so x0 is never pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      for (int i = 1; i < NR_GPR; i++) begin
        if (i_set_en && i_set_idx == RID_W'(i))
          r_pending[i] <= 1'b1;
        else if (i_clr_en && i_clr_idx == RID_W'(i))
          r_pending[i] <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/idu_issue_ysyx_23060136.sv
// rtl/idu_issue_ysyx_23060136.sv - decode-issue stage: GPRs, bypass, interlock, output register
module idu_issue_ysyx_23060136
  import idu_pkg_ysyx_23060136::*;
#(
  parameter int XLEN   = IDU_XLEN,
  parameter int NR_GPR = NR_GPR_RV32I,
  localparam int RID_W = $clog2(NR_GPR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_inst,
  input  logic [RID_W-1:0] in_rs1,
  input  logic [RID_W-1:0] in_rs2,
  input  logic [RID_W-1:0] in_rd,
  input  logic             in_rd_wen,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_inst,
  output logic [XLEN-1:0]  out_rs1_data,
  output logic [XLEN-1:0]  out_rs2_data,
  output logic [RID_W-1:0] out_rd,
  output logic             out_rd_wen,
  input  logic             wb_valid,
  input  logic [RID_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic [31:0]      stall_cnt
);
  logic [XLEN-1:0] r_gpr [NR_GPR];
  idu_issue_t      r_out;
  logic            r_out_valid;
  logic [31:0]     r_stall_cnt;

  logic            w_p_rs1, w_p_rs2, w_p_rd;
  logic            w_out_conflict, w_hazard, w_accept, w_handshake, w_set_en;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;

  function automatic logic [XLEN-1:0] f_read(input logic [RID_W-1:0] idx);
    if (idx == '0)
      return '0;
    if (wb_valid && wb_rd == idx)
      return wb_data;
    return r_gpr[idx];
  endfunction

  assign w_rs1_data = f_read(in_rs1);
  assign w_rs2_data = f_read(in_rs2);

  // The held entry is not in the scoreboard yet, so compare against it directly
  assign w_out_conflict = r_out_valid && out_rd_wen && out_rd != '0 &&
                          (out_rd == in_rs1 || out_rd == in_rs2 || out_rd == in_rd);
  assign w_hazard = in_valid && ((in_rs1 != '0 && w_p_rs1) ||
                                 (in_rs2 != '0 && w_p_rs2) ||
                                 (in_rd_wen && in_rd != '0 && w_p_rd) ||
                                 w_out_conflict);
  assign in_ready    = !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = r_out_valid && out_ready;
  assign w_set_en    = w_handshake && !flush && out_rd_wen && out_rd != '0;

  idu_scoreboard_ysyx_23060136 #(.NR_GPR(NR_GPR), .RID_W(RID_W)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_set_en  (w_set_en),
    .i_set_idx (out_rd),
    .i_clr_en  (wb_valid),
    .i_clr_idx (wb_rd),
    .i_q0_idx  (in_rs1),
    .i_q1_idx  (in_rs2),
    .i_q2_idx  (in_rd),
    .o_q0_pend (w_p_rs1),
    .o_q1_pend (w_p_rs2),
    .o_q2_pend (w_p_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_GPR; i++)
        r_gpr[i] <= '0;
    end else if (wb_valid && wb_rd != '0) begin
      r_gpr[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= '{pc: in_pc, inst: in_inst, rs1_data: w_rs1_data, rs2_data: w_rs2_data,
                       rd: RID_MAX_W'(in_rd), rd_wen: in_rd_wen};
      r_out_valid <= 1'b1;
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_hazard)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign out_valid    = r_out_valid;
  assign out_pc       = r_out.pc;
  assign out_inst     = r_out.inst;
  assign out_rs1_data = r_out.rs1_data;
  assign out_rs2_data = r_out.rs2_data;
  assign out_rd       = r_out.rd[RID_W-1:0];
  assign out_rd_wen   = r_out.rd_wen;
  assign stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_idu_issue_ysyx_23060136.sv
// tb/tb_idu_issue_ysyx_23060136.sv - bench for the decode-issue stage, RV32I and RV32E builds
module tb_idu_issue_ysyx_23060136;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_rd_wen, out_valid, out_ready, out_rd_wen;
  logic        wb_valid, flush;
  logic [31:0] in_pc, in_inst, out_pc, out_inst, out_rs1_data, out_rs2_data, wb_data, stall_cnt;
  logic [4:0]  in_rs1, in_rs2, in_rd, out_rd, wb_rd;

  logic        s_in_valid, s_in_ready, s_in_rd_wen, s_out_valid, s_out_ready, s_out_rd_wen;
  logic        s_wb_valid, s_flush;
  logic [31:0] s_in_pc, s_in_inst, s_out_pc, s_out_inst, s_out_rs1_data, s_out_rs2_data;
  logic [31:0] s_wb_data, s_stall_cnt;
  logic [3:0]  s_in_rs1, s_in_rs2, s_in_rd, s_out_rd, s_wb_rd;

  idu_issue_ysyx_23060136 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  idu_issue_ysyx_23060136 #(.NR_GPR(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pc(s_in_pc),
    .in_inst(s_in_inst), .in_rs1(s_in_rs1), .in_rs2(s_in_rs2), .in_rd(s_in_rd),
    .in_rd_wen(s_in_rd_wen), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_pc(s_out_pc), .out_inst(s_out_inst), .out_rs1_data(s_out_rs1_data),
    .out_rs2_data(s_out_rs2_data), .out_rd(s_out_rd), .out_rd_wen(s_out_rd_wen),
    .wb_valid(s_wb_valid), .wb_rd(s_wb_rd), .wb_data(s_wb_data), .flush(s_flush),
    .stall_cnt(s_stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int iv, rs1, rs2, rd, wen, ordy, wbv, wbrd;
    logic [31:0] wbd;
    int fl, exp_rdy, exp_ov;
    logic [31:0] exp_r1, exp_r2, exp_pc, exp_stall;
  } vec_t;
  vec_t tbl[13];

  // Reference state: architectural registers, outstanding writers, issued entry
  logic [31:0] m_gpr [32];
  bit          m_pend [32];
  bit          m_ov, m_wen;
  int          m_rd;
  logic [31:0] m_pc, m_inst, m_r1, m_r2, m_stall;

  function automatic bit m_p(int r);
    return m_pend[r] && !(wb_valid && int'(wb_rd) == r);
  endfunction

  function automatic logic [31:0] m_val(int r);
    if (r == 0) return 32'd0;
    if (wb_valid && int'(wb_rd) == r) return wb_data;
    return m_gpr[r];
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_pc = 0; in_inst = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wen = 0;
    out_ready = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int r1, r2, rd;
    bit hz, rdy, hs;
    logic [31:0] v1, v2;

    idle_inputs();
    s_in_valid = 0; s_in_pc = 0; s_in_inst = 0; s_in_rs1 = 0; s_in_rs2 = 0; s_in_rd = 0;
    s_in_rd_wen = 0; s_out_ready = 0; s_wb_valid = 0; s_wb_rd = 0; s_wb_data = 0; s_flush = 0;
    do_reset();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_out_rs1", out_rs1_data, 32'd0);
    chk("reset_stall", stall_cnt, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // iv rs1 rs2 rd wen ordy wbv wbrd wbd fl | rdy ov r1 r2 pc stall (outputs after the edge)
    tbl[0]  = '{1, 5, 0, 1, 0, 1, 1, 5, 32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF, 0, 32'h100, 0};
    tbl[1]  = '{1, 5, 0, 3, 1, 1, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 32'h104, 0};
    tbl[2]  = '{1, 0, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{1, 0, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
    tbl[4]  = '{1, 0, 3, 4, 1, 1, 1, 3, 32'h55, 0, 1, 1, 0, 32'h55, 32'h110, 2};
    tbl[5]  = '{1, 0, 0, 0, 1, 1, 1, 0, 32'h1234, 0, 1, 1, 0, 0, 32'h114, 2};
    tbl[6]  = '{1, 0, 0, 6, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 32'h118, 2};
    tbl[7]  = '{1, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h118, 2};
    tbl[8]  = '{1, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h118, 2};
    tbl[9]  = '{1, 1, 2, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h118, 2};
    tbl[10] = '{1, 1, 2, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2};
    tbl[11] = '{1, 4, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    tbl[12] = '{1, 4, 0, 8, 1, 1, 1, 4, 32'h44, 0, 1, 1, 32'h44, 0, 32'h130, 3};

    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].iv != 0; in_pc = 32'h100 + 32'(i * 4); in_inst = ~in_pc;
      in_rs1 = 5'(tbl[i].rs1); in_rs2 = 5'(tbl[i].rs2); in_rd = 5'(tbl[i].rd);
      in_rd_wen = tbl[i].wen != 0; out_ready = tbl[i].ordy != 0; wb_valid = tbl[i].wbv != 0;
      wb_rd = 5'(tbl[i].wbrd); wb_data = tbl[i].wbd; flush = tbl[i].fl != 0;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'(tbl[i].exp_ov));
      chk($sformatf("vec%0d_stall", i), stall_cnt, tbl[i].exp_stall);
      if (tbl[i].exp_ov != 0) begin
        chk($sformatf("vec%0d_rs1", i), out_rs1_data, tbl[i].exp_r1);
        chk($sformatf("vec%0d_rs2", i), out_rs2_data, tbl[i].exp_r2);
        chk($sformatf("vec%0d_pc", i), out_pc, tbl[i].exp_pc);
      end
    end

    // Asynchronous reset with an entry held and a nonzero stall count
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_stall", stall_cnt, 32'd0);
    chk("midrst_out_pc", out_pc, 32'd0);
    @(negedge clk) rst = 1'b0;
    in_valid = 1; in_rs1 = 5; out_ready = 1;
    @(negedge clk);
    chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("postrst_x5", out_rs1_data, 32'd0);

    idle_inputs();
    do_reset();
    for (int i = 0; i < 32; i++) begin m_gpr[i] = 0; m_pend[i] = 0; end
    m_ov = 0; m_wen = 0; m_rd = 0; m_pc = 0; m_inst = 0; m_r1 = 0; m_r2 = 0; m_stall = 0;

    for (int c = 0; c < 1500; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_pc = $urandom; in_inst = $urandom;
      in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
      in_rd = 5'($urandom_range(0, 7)); in_rd_wen = $urandom_range(0, 1) != 0;
      wb_valid = $urandom_range(0, 9) < 4; wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      flush = $urandom_range(0, 19) == 0;
      out_ready = flush ? 1'b0 : ($urandom_range(0, 9) < 7);
      @(negedge clk);
      r1 = int'(in_rs1); r2 = int'(in_rs2); rd = int'(in_rd);
      hz = in_valid && ((r1 != 0 && m_p(r1)) || (r2 != 0 && m_p(r2)) ||
                        (in_rd_wen && rd != 0 && m_p(rd)) ||
                        (m_ov && m_wen && m_rd != 0 && (m_rd == r1 || m_rd == r2 || m_rd == rd)));
      rdy = !flush && !hz && (!m_ov || out_ready);
      chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, rdy});
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("rnd_stall", stall_cnt, m_stall);
      if (m_ov) begin
        chk("rnd_pc", out_pc, m_pc);
        chk("rnd_inst", out_inst, m_inst);
        chk("rnd_rs1", out_rs1_data, m_r1);
        chk("rnd_rs2", out_rs2_data, m_r2);
        chk("rnd_rd", {27'd0, out_rd}, 32'(m_rd));
        chk("rnd_rd_wen", {31'd0, out_rd_wen}, {31'd0, m_wen});
      end
      @(posedge clk);
      v1 = m_val(r1); v2 = m_val(r2);
      hs = m_ov && out_ready && !flush;
      if (wb_valid) m_pend[int'(wb_rd)] = 0;
      if (hs && m_wen && m_rd != 0) m_pend[m_rd] = 1;
      if (wb_valid && wb_rd != 0) m_gpr[int'(wb_rd)] = wb_data;
      if (hz) m_stall = m_stall + 1;
      if (flush) m_ov = 0;
      else if (in_valid && rdy) begin
        m_ov = 1; m_pc = in_pc; m_inst = in_inst; m_r1 = v1; m_r2 = v2; m_rd = rd; m_wen = in_rd_wen;
      end else if (hs) m_ov = 0;
      #1;
    end
    idle_inputs();

    // RV32E build: top register x15 write, bypass-free read, interlock
    s_wb_valid = 1; s_wb_rd = 15; s_wb_data = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    s_wb_valid = 0;
    s_in_valid = 1; s_in_rs1 = 15; s_in_rs2 = 0; s_in_rd = 15; s_in_rd_wen = 1; s_out_ready = 1;
    @(negedge clk);
    chk("e_in_ready_x15", {31'd0, s_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("e_out_valid", {31'd0, s_out_valid}, 32'd1);
    chk("e_rs1_x15", s_out_rs1_data, 32'hA5A5A5A5);
    s_in_rs1 = 0; s_in_rs2 = 15; s_in_rd = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("e_raw_stall%0d", k), {31'd0, s_in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("e_stall_cnt", s_stall_cnt, 32'd2);
    s_wb_valid = 1; s_wb_rd = 15; s_wb_data = 32'h55;
    @(negedge clk);
    chk("e_raw_release", {31'd0, s_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("e_rs2_bypass", s_out_rs2_data, 32'h55);
    s_wb_valid = 0; s_in_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
